pulse_transmitter_symbol_sequencer: RTL and testbench

PULSE_TRANSMITTER_SYMBOL_SEQUENCER -- requirements
Module: pulse_transmitter_symbol_sequencer

---
 rtl/pulse_transmitter_symbol_sequencer.sv | 170 +++++++++++++++++
 tb/tb_pulse_transmitter_symbol_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_transmitter_symbol_sequencer.sv
// Pulse transmitter symbol sequencer.
// Plays a programmable list of {level, prescaler, duration} symbols by
// configuring an external countdown timer one symbol at a time, optionally
// repeating the list, and drives the transmitted waveform level.
module pulse_transmitter_symbol_sequencer #(
    parameter  int PRESCALER_WIDTH = 16,
    parameter  int TIMER_WIDTH     = 8,
    parameter  int DEPTH           = 8,
    localparam int PW              = $clog2(PRESCALER_WIDTH),
    localparam int AW              = $clog2(DEPTH),
    localparam int EW              = 1 + PW + TIMER_WIDTH
) (
    input  logic                   clk,
    input  logic                   sys_rst_n,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [EW-1:0]          wr_data,
    input  logic [AW-1:0]          last_index,
    input  logic [7:0]             loop_count,
    input  logic                   idle_level,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   timer_pulse,
    output logic                   timer_en,
    output logic [PW-1:0]          timer_prescaler,
    output logic [TIMER_WIDTH-1:0] timer_duration,
    output logic                   pulse_out,
    output logic                   busy,
    output logic                   done,
    output logic [AW-1:0]          symbol_index
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic                   level;
        logic [PW-1:0]          prescaler;
        logic [TIMER_WIDTH-1:0] duration;
    } entry_t;

    entry_t                 mem [DEPTH];
    state_t                 state, state_n;
    logic [AW-1:0]          index, index_n;
    logic [7:0]             loops_left, loops_n;
    logic                   timer_en_n, pulse_n, busy_n, done_n;
    logic [PW-1:0]          prescaler_n;
    logic [TIMER_WIDTH-1:0] duration_n;
    logic [AW-1:0]          symbol_index_n;
    logic                   load_req;
    entry_t                 load_entry;

    // Symbol buffer: writable at any time, read when a symbol is loaded.
    // NOTE: storage-only array, deliberately not reset, so it maps to plain flops/RAM without a reset tree.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= entry_t'(wr_data);
    end

    // State and registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state           <= IDLE;
            index           <= '0;
            loops_left      <= '0;
            timer_en        <= 1'b0;
            timer_prescaler <= '0;
            timer_duration  <= '0;
            pulse_out       <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            symbol_index    <= '0;
        end else begin
            state           <= state_n;
            index           <= index_n;
            loops_left      <= loops_n;
            timer_en        <= timer_en_n;
            timer_prescaler <= prescaler_n;
            timer_duration  <= duration_n;
            pulse_out       <= pulse_n;
            busy            <= busy_n;
            done            <= done_n;
            symbol_index    <= symbol_index_n;
        end
    end

    // Next-state and next-output decode; a symbol load and stop override the per-state defaults.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_n        = state;
        index_n        = index;
        loops_n        = loops_left;
        timer_en_n     = 1'b0;
        prescaler_n    = timer_prescaler;
        duration_n     = timer_duration;
        pulse_n        = pulse_out;
        busy_n         = 1'b0;
        done_n         = 1'b0;
        symbol_index_n = symbol_index;
        load_req       = 1'b0;
        load_entry     = '0;

        case (state)
            IDLE: begin
                pulse_n = idle_level;
                if (start && !stop) begin
                    index_n  = '0;
                    loops_n  = loop_count;
                    load_req = 1'b1;
                end
            end
            LOAD: begin
                state_n    = RUN;
                timer_en_n = 1'b1;
                busy_n     = 1'b1;
            end
            RUN: begin
                timer_en_n = 1'b1;
                busy_n     = 1'b1;
                if (timer_pulse) begin
                    if (index < last_index) begin
                        index_n  = index + AW'(1);
                        load_req = 1'b1;
                    end else if (loops_left != 8'd0) begin
                        loops_n  = loops_left - 8'd1;
                        index_n  = '0;
                        load_req = 1'b1;
                    end else begin
                        state_n    = DONE;
                        timer_en_n = 1'b0;
                        busy_n     = 1'b0;
                        done_n     = 1'b1;
                        pulse_n    = idle_level;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                pulse_n = idle_level;
            end
            default: state_n = IDLE;
        endcase

        // Latch the next symbol's configuration; the timer stays disabled for the LOAD cycle.
        if (load_req) begin
            load_entry     = mem[index_n];
            state_n        = LOAD;
            timer_en_n     = 1'b0;
            busy_n         = 1'b1;
            pulse_n        = load_entry.level;
            prescaler_n    = load_entry.prescaler;
            duration_n     = load_entry.duration;
            symbol_index_n = index_n;
        end

        // Abort wins over everything, including a same-cycle timer_pulse.
        if (stop && state != IDLE) begin
            state_n    = IDLE;
            timer_en_n = 1'b0;
            busy_n     = 1'b0;
            done_n     = 1'b0;
            pulse_n    = idle_level;
        end
    end

endmodule

// File: tb/tb_pulse_transmitter_symbol_sequencer.sv
// Testbench for pulse_transmitter_symbol_sequencer: acts as the countdown
// timer, predicts the symbol load sequence from the buffer contents and
// playback settings, and checks every LOAD and done event from a monitor.
module tb_pulse_transmitter_symbol_sequencer;

    localparam int PW    = 4;
    localparam int TW    = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int EW    = 1 + PW + TW;

    logic          clk;
    logic          sys_rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [EW-1:0] wr_data;
    logic [AW-1:0] last_index;
    logic [7:0]    loop_count;
    logic          idle_level;
    logic          start;
    logic          stop;
    logic          timer_pulse;
    logic          timer_en;
    logic [PW-1:0] timer_prescaler;
    logic [TW-1:0] timer_duration;
    logic          pulse_out;
    logic          busy;
    logic          done;
    logic [AW-1:0] symbol_index;

    pulse_transmitter_symbol_sequencer dut (
        .clk             (clk),
        .sys_rst_n       (sys_rst_n),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .last_index      (last_index),
        .loop_count      (loop_count),
        .idle_level      (idle_level),
        .start           (start),
        .stop            (stop),
        .timer_pulse     (timer_pulse),
        .timer_en        (timer_en),
        .timer_prescaler (timer_prescaler),
        .timer_duration  (timer_duration),
        .pulse_out       (pulse_out),
        .busy            (busy),
        .done            (done),
        .symbol_index    (symbol_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit            is_done;
        int            idx;
        logic [EW-1:0] ent;
    } exp_t;

    exp_t          expq[$];
    logic [EW-1:0] shadow [DEPTH];
    int            checks   = 0;
    int            failures = 0;
    bit            prev_load = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [EW-1:0] mk(input int level, input int presc, input int dur);
        return {1'(level), PW'(presc), TW'(dur)};
    endfunction

    // Monitor: every LOAD cycle and every done strobe must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (!sys_rst_n) begin
            prev_load = 1'b0;
        end else begin
            if (prev_load && busy) check("timer_en_after_load", 32'(timer_en), 1);
            prev_load = 1'b0;
            if (busy && !timer_en) begin
                prev_load = 1'b1;
                if (expq.size() == 0) begin
                    check("unexpected_load_idx", 32'(symbol_index), 32'hFFFF_FFFF);
                end else begin
                    e = expq.pop_front();
                    check("event_kind_load", 32'(e.is_done), 0);
                    check("symbol_index", 32'(symbol_index), 32'(e.idx));
                    check("pulse_out_level", 32'(pulse_out), 32'(e.ent[EW-1]));
                    check("timer_prescaler", 32'(timer_prescaler), 32'(e.ent[TW +: PW]));
                    check("timer_duration", 32'(timer_duration), 32'(e.ent[TW-1:0]));
                end
            end
            if (done) begin
                if (expq.size() == 0) begin
                    check("unexpected_done", 32'(done), 0);
                end else begin
                    e = expq.pop_front();
                    check("event_kind_done", 32'(e.is_done), 1);
                    check("done_pulse_level", 32'(pulse_out), 32'(idle_level));
                    check("done_timer_en", 32'(timer_en), 0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int a, input logic [EW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        shadow[a] = d;
    endtask

    task automatic wait_en_rise(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 64; c++) begin
            tick();
            if (timer_en) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("timer_en_rise_timeout", 0, 1);
    endtask

    // Reference model: pass-by-pass list of loaded entries, then one done.
    // A write issued during the RUN of load number wk is visible to later loads only.
    task automatic build(input int last, input int loops, input int wk, input int waddr,
                         input logic [EW-1:0] wdata, input bit abort);
        exp_t e;
        int   n = 0;
        for (int p = 0; p <= loops; p++) begin
            for (int i = 0; i <= last; i++) begin
                e.is_done = 1'b0;
                e.idx     = i;
                e.ent     = (wk >= 0 && n > wk && i == waddr) ? wdata : shadow[i];
                expq.push_back(e);
                n++;
                if (abort) return;
            end
        end
        e.is_done = 1'b1;
        e.idx     = 0;
        e.ent     = '0;
        expq.push_back(e);
    endtask

    task automatic play(input int last, input int loops, input int dly, input bit keep_start,
                        input int wk, input int waddr, input logic [EW-1:0] wdata, input bit abort);
        int total;
        bit ok;
        total      = (last + 1) * (loops + 1);
        last_index = AW'(last);
        loop_count = 8'(loops);
        build(last, loops, wk, waddr, wdata, abort);
        start = 1'b1;
        for (int n = 0; n < total; n++) begin
            wait_en_rise(ok);
            if (!ok) begin
                expq.delete();
                start = 1'b0;
                return;
            end
            if (n == 0 && !keep_start) start = 1'b0;
            repeat (dly - 1) tick();
            if (n == wk) write_entry(waddr, wdata);
            timer_pulse = 1'b1;
            if (abort) stop = 1'b1;
            tick();
            timer_pulse = 1'b0;
            stop        = 1'b0;
            if (abort) begin
                check("abort_busy", 32'(busy), 0);
                check("abort_timer_en", 32'(timer_en), 0);
                check("abort_done", 32'(done), 0);
                check("abort_pulse_out", 32'(pulse_out), 32'(idle_level));
                repeat (4) tick();
                check("abort_no_more_events", 32'(expq.size()), 0);
                expq.delete();
                return;
            end
        end
        check("done_after_last_pulse", 32'(done), 1);
        check("busy_in_done", 32'(busy), 0);
        tick();
        check("done_one_cycle", 32'(done), 0);
        check("events_drained", 32'(expq.size()), 0);
        expq.delete();
    endtask

    initial begin
        bit ok;
        int last, loops, dly, wk, wa;
        logic [EW-1:0] wd;

        sys_rst_n   = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        last_index  = '0;
        loop_count  = '0;
        idle_level  = 1'b1;
        start       = 1'b0;
        stop        = 1'b0;
        timer_pulse = 1'b0;
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;

        // Reset state and idle tracking.
        repeat (2) tick();
        check("rst_pulse_out", 32'(pulse_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_timer_en", 32'(timer_en), 0);
        check("rst_symbol_index", 32'(symbol_index), 0);
        sys_rst_n = 1'b1;
        tick();
        check("idle_follows_level_1", 32'(pulse_out), 1);
        check("idle_done", 32'(done), 0);
        idle_level = 1'b0;
        tick();
        check("idle_follows_level_0", 32'(pulse_out), 0);

        for (int i = 0; i < DEPTH; i++) write_entry(i, mk(i & 1, i, 20 + i));
        write_entry(0, mk(1, 0, 5));
        write_entry(1, mk(0, 2, 3));
        write_entry(2, mk(1, 1, 7));

        // Single pass, timer_pulse four cycles after each enable.
        play(2, 0, 4, 1'b0, -1, 0, '0, 1'b0);
        // Looping over two entries three times.
        play(1, 2, 2, 1'b0, -1, 0, '0, 1'b0);
        // Abort with a simultaneous timer_pulse at index 0.
        idle_level = 1'b1;
        play(2, 0, 3, 1'b0, -1, 0, '0, 1'b1);

        // start and stop together in IDLE keep the sequencer idle.
        start = 1'b1;
        stop  = 1'b1;
        repeat (3) tick();
        check("start_stop_idle_busy", 32'(busy), 0);
        start = 1'b0;
        stop  = 1'b0;
        tick();

        // start held through playback: no restart; still high after done: new playback.
        play(1, 0, 2, 1'b1, -1, 0, '0, 1'b0);
        play(2, 0, 2, 1'b0, -1, 0, '0, 1'b0);

        // Rewrite entry 1 while it plays: current symbol intact, next pass uses it.
        play(2, 1, 3, 1'b0, 1, 1, mk(0, 2, 9), 1'b0);

        // Asynchronous reset in the middle of RUN.
        idle_level = 1'b0;
        last_index = AW'(2);
        loop_count = 8'd0;
        build(2, 0, -1, 0, '0, 1'b1);
        start = 1'b1;
        wait_en_rise(ok);
        start = 1'b0;
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("midrun_rst_timer_en", 32'(timer_en), 0);
        check("midrun_rst_busy", 32'(busy), 0);
        check("midrun_rst_pulse_out", 32'(pulse_out), 0);
        check("midrun_rst_duration", 32'(timer_duration), 0);
        expq.delete();
        idle_level = 1'b1;
        tick();
        sys_rst_n = 1'b1;
        tick();
        check("post_rst_pulse_out", 32'(pulse_out), 1);

        // Randomized playbacks.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < DEPTH; i++)
                write_entry(i, EW'($urandom));
            idle_level = 1'($urandom);
            tick();
            last  = int'($urandom_range(0, DEPTH - 1));
            loops = int'($urandom_range(0, 2));
            dly   = int'($urandom_range(1, 5));
            wk    = ($urandom_range(0, 1) == 1) ? 0 : -1;
            wa    = int'($urandom_range(0, last));
            wd    = EW'($urandom);
            play(last, loops, dly, 1'b0, wk, wa, wd, 1'b0);
            tick();
        end

        // Maximum loop count gives 256 passes.
        play(0, 255, 1, 1'b0, -1, 0, '0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
